// File: rtl/apple2_disk_pkg.sv
// apple2_disk_pkg
// Definitions shared by the disk track loader and the track write-back block:
//   SECTORS        - 512-byte SD sectors that make up one disk track
//   wb_state_t     - write-back FSM state encoding
//   track_base_lba - first SD sector (LBA) of a given track
package apple2_disk_pkg;

    localparam int SECTORS = 13;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        WAIT_ACK = 3'd2,
        XFER     = 3'd3,
        NEXT     = 3'd4
    } wb_state_t;

    // Tracks are stored back to back in the image, SECTORS sectors each.
    function automatic logic [31:0] track_base_lba(input logic [5:0] trk,
                                                   input int unsigned sectors);
        return 32'(sectors) * {26'd0, trk};
    endfunction

endpackage

// File: rtl/track_writeback.sv
// track_writeback
// Writes the track held in track RAM back to the mounted disk image, one SD
// sector at a time, whenever the track has been modified and a flush is asked.
// Ports:
//   clk_sys        in   system clock, all logic on its rising edge
//   reset          in   synchronous active-high reset
//   track          in   track number currently held in track RAM
//   track_dirty    in   pulse: a byte was written into track RAM
//   flush_req      in   pulse: write the track back to the image
//   img_mounted    in   pulse: a new image was mounted
//   img_size       in   mounted image size in bytes (0 = no image)
//   sd_lba         out  SD sector address of the current write
//   sd_wr          out  SD write request
//   sd_ack         in   SD host acknowledge (high while a sector transfers)
//   sd_buff_addr   in   byte index inside the sector being transferred
//   sd_buff_din    out  byte handed to the SD host
//   track_ram_addr out  track RAM read address {sector, sd_buff_addr}
//   track_ram_do   in   track RAM read data, one cycle after the address
//   busy           out  CPU wait request while a flush runs
//   done           out  single-cycle completion pulse
module track_writeback #(
    parameter int SECTORS = apple2_disk_pkg::SECTORS
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [5:0]  track,
    input  logic        track_dirty,
    input  logic        flush_req,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    output logic [31:0] sd_lba,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    output logic [7:0]  sd_buff_din,
    output logic [12:0] track_ram_addr,
    input  logic [7:0]  track_ram_do,
    output logic        busy,
    output logic        done
);
    import apple2_disk_pkg::*;

    wb_state_t   r_state;
    wb_state_t   w_state_nxt;
    logic        r_dirty;
    logic        r_abort;
    logic        r_ack_prev;
    logic        r_sd_wr;
    logic        r_busy;
    logic        r_done;
    logic [3:0]  r_sector;
    logic [31:0] r_lba;
    logic [5:0]  r_track;

    logic w_ack_rise;
    logic w_ack_fall;
    logic w_img_ok;
    logic w_last;
    logic w_start;
    logic w_skip;
    logic w_abort_now;

    assign w_ack_rise  = sd_ack & ~r_ack_prev;
    assign w_ack_fall  = ~sd_ack & r_ack_prev;
    assign w_img_ok    = (img_size != 64'd0);
    assign w_last      = (r_sector == 4'(SECTORS - 1));
    // A mount arriving in the very cycle the ack falls still ends the flush.
    assign w_abort_now = r_abort | img_mounted;

    assign track_ram_addr = {r_sector, sd_buff_addr};
    assign sd_buff_din    = track_ram_do;
    assign sd_lba         = r_lba;
    assign sd_wr          = r_sd_wr;
    assign busy           = r_busy;
    assign done           = r_done;

    // Next-state decode and flush start/skip decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_skip      = 1'b0;
        case (r_state)
            IDLE: begin
                if (flush_req) begin
                    if (r_dirty && w_img_ok) begin
                        w_start     = 1'b1;
                        w_state_nxt = ARM;
                    end else begin
                        w_skip = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ARM: begin
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (w_ack_rise) begin
                    w_state_nxt = XFER;
                end else begin
                    w_state_nxt = WAIT_ACK;
                end
            end
            XFER: begin
                if (w_ack_fall) begin
                    w_state_nxt = w_abort_now ? IDLE : NEXT;
                end else begin
                    w_state_nxt = XFER;
                end
            end
            NEXT: begin
                w_state_nxt = w_last ? IDLE : ARM;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dirty tracking, ack history and per-state datapath/output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dirty    <= 1'b0;
            r_abort    <= 1'b0;
            r_ack_prev <= 1'b0;
            r_sd_wr    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sector   <= 4'd0;
            r_lba      <= 32'd0;
            r_track    <= 6'd0;
        end else begin
            r_ack_prev <= sd_ack;
            r_done     <= 1'b0;

            // A write landing in the cycle the flush starts keeps the track dirty.
            if (img_mounted) begin
                r_dirty <= 1'b0;
            end else if (track_dirty) begin
                r_dirty <= 1'b1;
            end else if (w_start) begin
                r_dirty <= 1'b0;
            end

            if (img_mounted && (r_state != IDLE)) begin
                r_abort <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_abort <= 1'b0;
                    r_sd_wr <= 1'b0;
                    if (w_start) begin
                        r_track  <= track;
                        r_sector <= 4'd0;
                        r_lba    <= track_base_lba(track, SECTORS);
                        r_busy   <= 1'b1;
                    end
                    if (w_skip) begin
                        r_done <= 1'b1;
                    end
                end
                ARM: begin
                    r_sd_wr <= 1'b1;
                end
                WAIT_ACK: begin
                    if (w_ack_rise) begin
                        r_sd_wr <= 1'b0;
                    end
                end
                XFER: begin
                    if (w_ack_fall && w_abort_now) begin
                        r_busy <= 1'b0;
                    end
                end
                NEXT: begin
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_sector <= r_sector + 4'd1;
                        r_lba    <= r_lba + 32'd1;
                    end
                end
                default: begin
                    r_sd_wr <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_track_writeback.sv
// tb_track_writeback
// Directed + randomized bench for track_writeback. An SD host model serves
// sector writes and captures data; a track RAM model supplies n^k patterns.
module tb_track_writeback;
    import apple2_disk_pkg::*;

    localparam int NSEC = 13;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  track = 6'd0;
    logic        track_dirty = 1'b0;
    logic        flush_req = 1'b0;
    logic        img_mounted = 1'b0;
    logic [63:0] img_size = 64'd0;
    logic [31:0] sd_lba;
    logic        sd_wr;
    logic        sd_ack = 1'b0;
    logic [8:0]  sd_buff_addr = 9'd0;
    logic [7:0]  sd_buff_din;
    logic [12:0] track_ram_addr;
    logic [7:0]  track_ram_do;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    // reference state: does the track hold unsaved data, is an image present
    bit model_dirty = 1'b0;

    logic [7:0] ram [8192];
    logic [7:0] cap [NSEC*512];

    int wr_pulses = 0;
    int done_pulses = 0;
    int busy_cycles = 0;
    int idle_wr = 0;
    logic wr_q = 1'b0;

    track_writeback #(.SECTORS(NSEC)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .track          (track),
        .track_dirty    (track_dirty),
        .flush_req      (flush_req),
        .img_mounted    (img_mounted),
        .img_size       (img_size),
        .sd_lba         (sd_lba),
        .sd_wr          (sd_wr),
        .sd_ack         (sd_ack),
        .sd_buff_addr   (sd_buff_addr),
        .sd_buff_din    (sd_buff_din),
        .track_ram_addr (track_ram_addr),
        .track_ram_do   (track_ram_do),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk_sys = ~clk_sys;

    // track RAM: one-cycle read latency
    always @(posedge clk_sys) track_ram_do <= ram[track_ram_addr];

    // pulse / activity counters sampled on the falling edge
    always @(negedge clk_sys) begin
        wr_q <= sd_wr;
        if (sd_wr && !wr_q) wr_pulses <= wr_pulses + 1;
        if (done) done_pulses <= done_pulses + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (sd_wr && dut.r_state == IDLE) idle_wr <= idle_wr + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic pulse_flush(input logic [5:0] trk);
        track = trk;
        flush_req = 1'b1;
        tick(1);
        flush_req = 1'b0;
    endtask

    task automatic pulse_dirty();
        track_dirty = 1'b1;
        tick(1);
        track_dirty = 1'b0;
        model_dirty = 1'b1;
    endtask

    // Serve one SD sector write: wait for sd_wr, ack, stream 512 bytes.
    task automatic serve_sector(input int n, input int exp_lba,
                                input bit do_dirty, input bit do_mount);
        int cnt = 0;
        int dly;
        while (sd_wr !== 1'b1 && cnt < 64) begin
            tick(1);
            cnt++;
        end
        check("sd_wr_request", sd_wr, 1'b1);
        check("sd_lba", sd_lba, 64'(exp_lba));
        check("busy_during_sector", busy, 1'b1);
        dly = $urandom_range(0, 3);
        repeat (dly) begin
            track = 6'($urandom);
            tick(1);
        end
        sd_ack = 1'b1;
        for (int k = 0; k < 512; k++) begin
            sd_buff_addr = 9'(k);
            if (k == 200 && do_dirty) begin
                track_dirty = 1'b1;
                model_dirty = 1'b1;
            end
            if (k == 200 && do_mount) begin
                img_mounted = 1'b1;
                model_dirty = 1'b0;
            end
            tick(1);
            track_dirty = 1'b0;
            img_mounted = 1'b0;
            cap[n*512 + k] = sd_buff_din;
        end
        check("sd_wr_dropped_after_ack", sd_wr, 1'b0);
        sd_ack = 1'b0;
        sd_buff_addr = 9'd0;
    endtask

    // Full flush with reference expectations derived from model_dirty/img_size.
    task automatic run_flush(input logic [5:0] trk, input int dirty_sector);
        int w0 = wr_pulses;
        int d0 = done_pulses;
        int b0 = busy_cycles;
        int cnt = 0;
        int errs = 0;
        bit exp_write = model_dirty && (img_size != 64'd0);
        for (int i = 0; i < NSEC*512; i++) cap[i] = ~8'((i / 512) ^ (i % 512));
        pulse_flush(trk);
        if (exp_write) begin
            model_dirty = 1'b0;
            for (int n = 0; n < NSEC; n++)
                serve_sector(n, NSEC * int'(trk) + n, (n == dirty_sector), 1'b0);
            while (done !== 1'b1 && cnt < 16) begin
                tick(1);
                cnt++;
            end
            check("done_after_last_sector", done, 1'b1);
            check("busy_low_at_done", busy, 1'b0);
            tick(2);
            check("sd_wr_pulse_count", 64'(wr_pulses - w0), 64'(NSEC));
            check("done_pulse_count", 64'(done_pulses - d0), 64'd1);
            for (int n = 0; n < NSEC; n++)
                for (int k = 0; k < 512; k++)
                    if (cap[n*512 + k] !== 8'(n ^ k)) errs++;
            check("track_bytes_mismatched", 64'(errs), 64'd0);
        end else begin
            check("skip_done_next_cycle", done, 1'b1);
            check("skip_busy", busy, 1'b0);
            tick(1);
            check("skip_done_single", done, 1'b0);
            tick(8);
            check("skip_no_sd_wr", 64'(wr_pulses - w0), 64'd0);
            check("skip_no_busy", 64'(busy_cycles - b0), 64'd0);
            check("skip_done_count", 64'(done_pulses - d0), 64'd1);
        end
    endtask

    initial begin
        int w0;
        int d0;
        int cnt;
        for (int n = 0; n < 16; n++)
            for (int k = 0; k < 512; k++)
                ram[n*512 + k] = 8'(n ^ k);

        // reset state
        tick(3);
        reset = 1'b0;
        check("reset_sd_wr", sd_wr, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sd_lba", sd_lba, 64'd0);
        check("reset_ram_addr_sector", 64'(track_ram_addr[12:9]), 64'd0);

        img_size = {32'($urandom), 32'($urandom)} | 64'd1;

        // flush with nothing dirty
        run_flush(6'd3, -1);

        // track 5, one write, full flush; track input wiggles during flush
        pulse_dirty();
        run_flush(6'd5, -1);

        // dirty again at sector 7, then a second flush rewrites everything
        pulse_dirty();
        run_flush(6'($urandom_range(0, 63)), 7);
        check("redirtied_by_write", 64'(model_dirty), 64'd1);
        run_flush(6'($urandom_range(0, 63)), -1);

        // no image: dirty track, flush does nothing but done
        img_size = 64'd0;
        pulse_dirty();
        run_flush(6'd11, -1);
        // mount clears dirty: a later flush with an image is still a no-op
        img_mounted = 1'b1;
        tick(1);
        img_mounted = 1'b0;
        model_dirty = 1'b0;
        img_size = 64'd143360;
        run_flush(6'd11, -1);

        // mount mid-flush: current sector completes, then idle without done
        pulse_dirty();
        w0 = wr_pulses;
        d0 = done_pulses;
        pulse_flush(6'd20);
        model_dirty = 1'b0;
        serve_sector(0, NSEC*20, 1'b0, 1'b0);
        serve_sector(1, NSEC*20 + 1, 1'b0, 1'b1);
        tick(30);
        check("mount_abort_wr_count", 64'(wr_pulses - w0), 64'd2);
        check("mount_abort_no_done", 64'(done_pulses - d0), 64'd0);
        check("mount_abort_busy", busy, 1'b0);
        run_flush(6'd20, -1);

        // reset during sector 3 with ack high
        pulse_dirty();
        pulse_flush(6'd9);
        model_dirty = 1'b0;
        for (int n = 0; n < 3; n++) serve_sector(n, NSEC*9 + n, 1'b0, 1'b0);
        cnt = 0;
        while (sd_wr !== 1'b1 && cnt < 64) begin
            tick(1);
            cnt++;
        end
        check("rst_test_sector3_lba", sd_lba, 64'(NSEC*9 + 3));
        sd_ack = 1'b1;
        tick(4);
        w0 = wr_pulses;
        d0 = done_pulses;
        reset = 1'b1;
        tick(1);
        check("midreset_sd_wr", sd_wr, 1'b0);
        check("midreset_busy", busy, 1'b0);
        check("midreset_state_idle", 64'(dut.r_state), 64'(IDLE));
        reset = 1'b0;
        sd_ack = 1'b0;
        tick(20);
        check("midreset_no_more_sectors", 64'(wr_pulses - w0), 64'd0);
        check("midreset_no_done", 64'(done_pulses - d0), 64'd0);
        run_flush(6'd9, -1);

        // randomized flushes
        for (int it = 0; it < 3; it++) begin
            if ($urandom_range(0, 1) == 1) pulse_dirty();
            tick($urandom_range(0, 5));
            run_flush(6'($urandom), -1);
        end

        check("sd_wr_never_in_idle", 64'(idle_wr), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/track_writeback.md
TRACK_WRITEBACK -- requirements
Module: track_writeback

Interface
REQ-001 SHALL provide parameter SECTORS, default 13, the number of 512-byte SD sectors per disk track.
REQ-002 SHALL provide ports: clk_sys  in  1  system clock (14 MHz domain); all logic is on its rising edge.
REQ-003 SHALL provide: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL provide: track  in  6  number of the track currently held in track RAM.
REQ-005 SHALL provide: track_dirty  in  1  single-cycle pulse, emitted when the disk controller writes a byte into track RAM.
REQ-006 SHALL provide: flush_req  in  1  single-cycle request to write the track back to the image.
REQ-007 SHALL provide: img_mounted  in  1  new-image pulse; img_size  in  64  mounted image size in bytes, where 0 means no image.
REQ-008 SHALL provide: sd_lba  out  32; sd_wr  out  1; sd_ack  in  1; sd_buff_addr  in  9; sd_buff_din  out  8.
REQ-009 SHALL provide: track_ram_addr  out  13  {sector[3:0], sd_buff_addr}; track_ram_do  in  8  track RAM read data, valid 1 cycle after the address.
REQ-010 SHALL provide: busy  out  1  CPU-wait request; done  out  1  single-cycle completion pulse.

Function
REQ-011 SHALL hold a dirty flag. track_dirty sets it. img_mounted clears it. When both arrive in the same cycle, img_mounted wins.
REQ-012 SHALL use FSM states IDLE, ARM, WAIT_ACK, XFER, NEXT.
REQ-013 In IDLE, flush_req with dirty=1 and img_size!=0 SHALL perform, on the next edge, all of: latch track, clear dirty, set sector=0, set sd_lba = SECTORS*track (zero-extended), assert busy, and go to ARM.
REQ-014 In IDLE, flush_req with dirty=0 or img_size=0 SHALL pulse done on the next cycle with no SD activity.
REQ-015 In ARM, the block SHALL assert sd_wr and go to WAIT_ACK.
REQ-016 In WAIT_ACK, on the sd_ack rising edge (registered previous value), the block SHALL drop sd_wr and go to XFER.
REQ-017 In XFER, on the sd_ack falling edge, the block SHALL go to NEXT.
REQ-018 In NEXT, if sector==SECTORS-1 the block SHALL drop busy, pulse done, and return to IDLE; otherwise it SHALL increment sector and sd_lba by 1 and go to ARM.
REQ-019 track_ram_addr SHALL be combinational {sector, sd_buff_addr}.
REQ-020 sd_buff_din SHALL equal track_ram_do, giving 1-cycle read latency, which hps_io absorbs.
REQ-021 While the block is not IDLE, flush_req SHALL be ignored.
REQ-022 A track_dirty pulse during a flush SHALL set dirty again, so that a later flush rewrites the track.
REQ-023 An img_mounted pulse mid-flush SHALL NOT abort the sector transfer in progress, and SHALL cause return to IDLE after the current sector's ack falls, without done.
REQ-024 Changes on the track input during a flush SHALL have no effect; only the latched track is used.
REQ-025 sd_wr SHALL be high for at most the ARM and WAIT_ACK period of each sector, and SHALL never be high in IDLE.

Reset
REQ-026 On reset, the block SHALL set: state=IDLE, sd_wr=0, busy=0, done=0, dirty=0, sector=0, sd_lba=0, previous ack=0.
REQ-027 Reset mid-flush SHALL drop sd_wr and busy on the same edge and SHALL discard remaining sectors.

Structure
REQ-028 SECTORS and the FSM state enumeration SHALL live in shared package apple2_disk_pkg, which the existing track loader also uses.
REQ-029 The block SHALL have no sub-modules; the sd_ack edge detector is inline.
REQ-030 In emu, hps_io sd_wr and sd_buff_din SHALL connect to this block. sd_lba and track RAM address SHALL be muxed with the loader, and the flush has priority.
REQ-031 busy SHALL be ORed into CPU_WAIT.

Verification
REQ-032 Bench SHALL check: track=5, one track_dirty, flush_req, model acks all sectors -> sd_lba sequence 65..77, 13 sd_wr pulses, one done pulse, busy low after the 13th ack falls.
REQ-033 Bench SHALL check: flush_req with dirty=0 -> done exactly 1 cycle after, sd_wr never asserted, busy never asserted.
REQ-034 Bench SHALL check: track RAM preloaded with sector n byte k = n^k, SD model capturing sd_buff_din at sd_buff_addr+1 cycle -> all 6656 captured bytes match.
REQ-035 Bench SHALL check: track_dirty at sector 7 of flush, then second flush_req after done -> second full 13-sector write occurs.
REQ-036 Bench SHALL check: reset asserted during sector 3 with sd_ack high -> next cycle sd_wr=0, busy=0, state IDLE; later flush_req with no dirty -> done only.
REQ-037 Bench SHALL check: img_size=0, dirty=1, flush_req -> no SD traffic, done pulse; then img_mounted -> dirty=0.
